// File: rtl/spi_frame_feeder.sv
// spi_frame_feeder: walks a snapshot of BCD digits, encodes each one to a
// 7-segment byte (plus decimal point), hands it to an external SPI shifter
// through a latch/start/complete handshake, and strobes the display latch
// once the whole frame has been shifted out. Any handshake wait that
// exceeds TIMEOUT cycles aborts the frame and pulses err.
module spi_frame_feeder #(
  parameter int NUM_DIGITS = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_req,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    colon,
  output logic [7:0]              parallel_data,
  output logic                    pd_latch,
  output logic                    spi_start,
  input  logic                    spi_complete,
  output logic                    disp_latch,
  output logic                    busy,
  output logic                    err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_STROBE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] digits_snap_q, digits_snap_d;
  logic                    colon_snap_q, colon_snap_d;
  logic [7:0]              pdata_q, pdata_d;

  logic stall;
  logic expired;

  // Segment byte for the digit at idx; dp marks the colon positions even on blanks.
  function automatic logic [7:0] encode_byte(input logic [4*NUM_DIGITS-1:0] d,
                                             input logic [2:0] idx,
                                             input logic c);
    logic [3:0] bcd;
    logic [6:0] seg;
    bcd = d[{idx, 2'b00} +: 4];
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return {c && (idx == 3'd4 || idx == 3'd2), seg};
  endfunction

  // Still waiting on the shifter this cycle, and whether this is the last allowed cycle.
  assign stall   = (state_q == S_WAIT_BUSY &&  spi_complete) ||
                   (state_q == S_WAIT_DONE && !spi_complete);
  assign expired = stall && (timer_q == TW'(TIMEOUT - 1));

  // State register: all sequencing state and the held output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      digits_snap_q <= '0;
      colon_snap_q  <= 1'b0;
      pdata_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      digits_snap_q <= digits_snap_d;
      colon_snap_q  <= colon_snap_d;
      pdata_q       <= pdata_d;
    end
  end

  // Next-state logic: frame sequencing, handshake timer, request merging.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    digits_snap_d = digits_snap_q;
    colon_snap_d  = colon_snap_q;
    pdata_d       = pdata_q;

    // Requests arriving mid-frame collapse into a single pending flag.
    if (frame_req && state_q != S_IDLE) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_req || pending_q) begin
          digits_snap_d = digits;
          colon_snap_d  = colon;
          idx_d         = 3'(NUM_DIGITS - 1);
          pending_d     = 1'b0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!spi_complete) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else if (expired) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (spi_complete) begin
          state_d = S_NEXT;
        end else if (expired) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == 3'd0) begin
          state_d = S_STROBE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = S_LOAD;
        end
      end
      S_STROBE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // The byte is registered on entry to LOAD so it is valid during pd_latch.
    if (state_d == S_LOAD) pdata_d = encode_byte(digits_snap_d, idx_d, colon_snap_d);
  end

  // Output decode: pulses come straight from the state, so reset clears them at once.
  always_comb begin
    parallel_data = pdata_q;
    pd_latch      = (state_q == S_LOAD);
    spi_start     = (state_q == S_START);
    disp_latch    = (state_q == S_STROBE);
    busy          = (state_q != S_IDLE);
    err           = expired;
  end

endmodule

// File: tb/tb_spi_frame_feeder.sv
// Testbench for spi_frame_feeder: shifter model, output monitor and one task per scenario.
module tb_spi_frame_feeder;

  localparam int ND = 6;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_req = 1'b0;
  logic          colon = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic          spi_complete;
  logic [7:0]    parallel_data;
  logic          pd_latch, spi_start, disp_latch, busy, err;

  int tests = 0;
  int fails = 0;

  spi_frame_feeder #(.NUM_DIGITS(ND), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .digits(digits), .colon(colon),
    .parallel_data(parallel_data), .pd_latch(pd_latch), .spi_start(spi_start),
    .spi_complete(spi_complete), .disp_latch(disp_latch), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Shifter model: goes busy for shift_len cycles after each spi_start, or never when stuck.
  int shift_len = 10;
  bit stuck = 1'b0;
  int sh_cnt = 0;
  always @(posedge clk) begin
    if (spi_start) sh_cnt <= shift_len;
    else if (sh_cnt > 0) sh_cnt <= sh_cnt - 1;
  end
  assign spi_complete = stuck || (sh_cnt == 0);

  // Reference encoding table.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  function automatic logic [47:0] frame_bytes(input logic [23:0] d, input logic c);
    logic [47:0] r = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      r = {r[39:0], c && (i == 4 || i == 2), seg_tab[d[4*i +: 4]]};
    end
    return r;
  endfunction

  // Monitor
  logic [127:0] got_vec = '0;
  int got_n = 0, disp_cnt = 0, err_cnt = 0, cyc = 0;
  int start_cyc = 0, err_cyc = 0, first_pd_cyc = 0, disp_cyc = 0;
  int viol_excl = 0, viol_hold = 0;
  logic [7:0] prev_pd = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (pd_latch) begin
      if (got_n == 0) first_pd_cyc = cyc;
      got_vec = {got_vec[119:0], parallel_data};
      got_n++;
    end
    if (spi_start) start_cyc = cyc;
    if (disp_latch) begin disp_cnt++; disp_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if ($countones({pd_latch, spi_start, disp_latch, err}) > 1) viol_excl++;
    if (rst_n && !pd_latch && parallel_data !== prev_pd) viol_hold++;
    prev_pd = parallel_data;
  end

  task automatic clear_mon();
    got_vec = '0; got_n = 0; disp_cnt = 0; err_cnt = 0;
  endtask

  task automatic pulse_req(input logic [23:0] d, input logic c);
    @(posedge clk); #1;
    digits = d; colon = c; frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_disp(input int n, input int limit);
    int k = 0;
    while (disp_cnt < n && k < limit) begin @(negedge clk); k++; end
    if (disp_cnt < n) begin
      tests++; fails++;
      $display("FAIL wait_disp: got %0d disp_latch pulses, required %0d", disp_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (parallel_data !== 8'h00) begin fails++; $display("FAIL rst_pdata: got %h required 00", parallel_data); end
    tests++; if (pd_latch !== 1'b0) begin fails++; $display("FAIL rst_pd_latch: got %b required 0", pd_latch); end
    tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL rst_spi_start: got %b required 0", spi_start); end
    tests++; if (disp_latch !== 1'b0) begin fails++; $display("FAIL rst_disp_latch: got %b required 0", disp_latch); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    // Request present at release must be taken on the very first edge.
    clear_mon();
    digits = 24'h987650; colon = 1'b1; frame_req = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    tests++; if (pd_latch !== 1'b1) begin fails++; $display("FAIL first_req: pd_latch got %b required 1", pd_latch); end
    tests++; if (parallel_data !== 8'h6F) begin fails++; $display("FAIL first_byte: got %h required 6f", parallel_data); end
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== frame_bytes(24'h987650, 1'b1)) begin
      fails++; $display("FAIL first_frame: got %h required %h", got_vec[47:0], frame_bytes(24'h987650, 1'b1)); end
    $display("[TB] reset/first frame: %h", got_vec[47:0]);
  endtask

  task automatic test_known();
    shift_len = 10;
    repeat (3) @(posedge clk);
    clear_mon();
    pulse_req(24'h123456, 1'b0);
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== 48'h065B4F666D7D || got_n != 6) begin
      fails++; $display("FAIL known_bytes: got %h (%0d bytes) required 065b4f666d7d (6 bytes)", got_vec[47:0], got_n); end
    tests++; if (disp_cyc - first_pd_cyc != ND * (shift_len + 4)) begin
      fails++; $display("FAIL known_latency: got %0d cycles required %0d", disp_cyc - first_pd_cyc, ND * (shift_len + 4)); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL known_busy_fall: got %b required 0", busy); end
    $display("[TB] known frame 123456: %h", got_vec[47:0]);
  endtask

  task automatic test_colon_blank();
    clear_mon();
    pulse_req(24'h000000, 1'b1);
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== 48'h3FBF3FBF3F3F) begin
      fails++; $display("FAIL colon_zero: got %h required 3fbf3fbf3f3f", got_vec[47:0]); end
    $display("[TB] colon zeros: %h", got_vec[47:0]);
    clear_mon();
    pulse_req(24'hA23456, 1'b0);
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== 48'h005B4F666D7D) begin
      fails++; $display("FAIL blank_first: got %h required 005b4f666d7d", got_vec[47:0]); end
    $display("[TB] blank first digit: %h", got_vec[47:0]);
    clear_mon();
    pulse_req(24'h1B3C56, 1'b1);
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== 48'h06804F806D7D) begin
      fails++; $display("FAIL blank_dp: got %h required 06804f806d7d", got_vec[47:0]); end
    $display("[TB] blank with dp: %h", got_vec[47:0]);
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      logic [23:0] d;
      logic c;
      d = 24'($urandom);
      c = 1'($urandom_range(0, 1));
      shift_len = $urandom_range(1, 12);
      clear_mon();
      pulse_req(d, c);
      // Inputs change while the frame is in flight and must be ignored.
      digits = 24'($urandom); colon = ~c;
      wait_disp(1, 600);
      tests++; if (got_vec[47:0] !== frame_bytes(d, c) || got_n != 6) begin
        fails++; $display("FAIL random_frame%0d: got %h required %h", f, got_vec[47:0], frame_bytes(d, c)); end
      $display("[TB] random frame %0d d=%h c=%b len=%0d: %h", f, d, c, shift_len, got_vec[47:0]);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    stuck = 1'b1;
    repeat (3) @(posedge clk);
    clear_mon();
    pulse_req(24'h111111, 1'b0);
    while (err_cnt == 0 && k < TO + 50) begin @(negedge clk); k++; end
    stuck = 1'b0;
    tests++; if (err_cyc - start_cyc != TO || err_cnt == 0) begin
      fails++; $display("FAIL timeout_delay: got %0d cycles (err seen %0d) required %0d", err_cyc - start_cyc, err_cnt, TO); end
    repeat (5) @(negedge clk);
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL timeout_err_count: got %0d required 1", err_cnt); end
    tests++; if (disp_cnt != 0) begin fails++; $display("FAIL timeout_disp: got %0d required 0", disp_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b required 0", busy); end
    $display("[TB] timeout: err after %0d cycles", err_cyc - start_cyc);
  endtask

  task automatic test_back_to_back();
    logic [23:0] da, db;
    logic ca, cb;
    da = 24'($urandom); db = 24'($urandom) ^ 24'h1;
    ca = 1'($urandom_range(0, 1)); cb = ~ca;
    shift_len = 4;
    clear_mon();
    pulse_req(da, ca);
    repeat (8) @(posedge clk);
    pulse_req(db, cb);
    repeat (5) @(posedge clk);
    pulse_req(db, cb);
    wait_disp(2, 1000);
    repeat (30) @(negedge clk);
    tests++; if (disp_cnt != 2) begin fails++; $display("FAIL pending_disp: got %0d required 2", disp_cnt); end
    tests++; if (got_vec[95:0] !== {frame_bytes(da, ca), frame_bytes(db, cb)} || got_n != 12) begin
      fails++; $display("FAIL pending_bytes: got %h required %h", got_vec[95:0], {frame_bytes(da, ca), frame_bytes(db, cb)}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pending_idle: got %b required 0", busy); end
    $display("[TB] back-to-back: %h", got_vec[95:0]);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic [23:0] db;
    shift_len = 10;
    clear_mon();
    pulse_req(24'h654321, 1'b1);
    while (got_n < 3 && k < 200) begin @(negedge clk); k++; end
    tests++; if (got_n < 3) begin fails++; $display("FAIL midrst_reach: got %0d bytes required 3", got_n); end
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({parallel_data, pd_latch, spi_start, disp_latch, err, busy} !== 13'h0) begin
      fails++; $display("FAIL midrst_outputs: got %h/%b%b%b%b%b required all zero",
                        parallel_data, pd_latch, spi_start, disp_latch, err, busy); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (disp_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_quiet: got disp=%0d busy=%b required 0/0", disp_cnt, busy); end
    db = 24'($urandom);
    clear_mon();
    pulse_req(db, 1'b0);
    wait_disp(1, 500);
    tests++; if (got_vec[47:0] !== frame_bytes(db, 1'b0) || got_n != 6) begin
      fails++; $display("FAIL midrst_next: got %h required %h", got_vec[47:0], frame_bytes(db, 1'b0)); end
    $display("[TB] after mid-frame reset: %h", got_vec[47:0]);
  endtask

  task automatic test_protocol();
    tests++; if (viol_excl != 0) begin fails++; $display("FAIL pulse_exclusive: got %0d overlaps required 0", viol_excl); end
    tests++; if (viol_hold != 0) begin fails++; $display("FAIL pdata_hold: got %0d changes outside LOAD required 0", viol_hold); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_colon_blank();
    test_random();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
